// File: rtl/csr_sequencer_if.sv
// ---------------------------------------------------------------------------
// csr_sequencer_if
// Purpose : groups the instruction-side request, the CSR-file bus and the
//           completion/write-back signals of csr_sequencer into one bundle.
// Modports:
//   master - the sequencer (drives strobes, CSR bus, completion outputs)
//   slave  - the environment (issues requests, models the CSR file)
// Signals :
//   request   : start, funct3, csr_sel, rs1_val, zimm, rs1_idx, rd_idx,
//               is_ecall, is_ebreak, is_mret, pc
//   CSR file  : csr_out, invalid (in); csr_addr, bus, addr, read, write,
//               trap, ret, write_type, trap_cause (out)
//   status    : busy, done, rd_we, rd_data, redirect, redirect_pc (out)
// ---------------------------------------------------------------------------
interface csr_sequencer_if;
  logic        start;
  logic [2:0]  funct3;
  logic [11:0] csr_sel;
  logic [31:0] rs1_val;
  logic [4:0]  zimm;
  logic [4:0]  rs1_idx;
  logic [4:0]  rd_idx;
  logic        is_ecall;
  logic        is_ebreak;
  logic        is_mret;
  logic [31:0] pc;
  logic [31:0] csr_out;
  logic        invalid;

  logic [11:0] csr_addr;
  logic [31:0] bus;
  logic [31:0] addr;
  logic        read;
  logic        write;
  logic        trap;
  logic        ret;
  logic [1:0]  write_type;
  logic [4:0]  trap_cause;
  logic        busy;
  logic        done;
  logic        rd_we;
  logic [31:0] rd_data;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    input  start, funct3, csr_sel, rs1_val, zimm, rs1_idx, rd_idx,
           is_ecall, is_ebreak, is_mret, pc, csr_out, invalid,
    output csr_addr, bus, addr, read, write, trap, ret, write_type,
           trap_cause, busy, done, rd_we, rd_data, redirect, redirect_pc
  );

  modport slave (
    output start, funct3, csr_sel, rs1_val, zimm, rs1_idx, rd_idx,
           is_ecall, is_ebreak, is_mret, pc, csr_out, invalid,
    input  csr_addr, bus, addr, read, write, trap, ret, write_type,
           trap_cause, busy, done, rd_we, rd_data, redirect, redirect_pc
  );
endinterface

// File: rtl/csr_sequencer.sv
// ---------------------------------------------------------------------------
// csr_sequencer
// Purpose : sequences a RISC-V SYSTEM instruction (CSRRW/RS/RC and their
//           immediate forms, ecall, ebreak, mret) against a CSR file:
//           read old value, optionally write, or raise a trap / return,
//           then report completion with register write-back or PC redirect.
// Ports   :
//   i_clk   - clock, all state changes on the rising edge
//   i_rst_n - synchronous active-low reset
//   cif     - csr_sequencer_if.master (request, CSR bus, status)
// Build option:
//   CSR_RO_CHECK_EN - when defined, a write aimed at a read-only CSR
//                     (csr_sel[11:10] == 2'b11) becomes an illegal-
//                     instruction trap (cause 2) instead of a write.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; all outputs 0
// S_READ  | read strobe, old CSR value captured
// S_WRITE | write strobe with write_type and write data on bus
// S_TRAP  | trap strobe, pc on bus/addr, cause on trap_cause
// S_RET   | ret strobe (mret)
// S_DONE  | one-cycle completion: rd write-back or redirect
// ---------------------------------------------------------------------------
module csr_sequencer (
  input  logic             i_clk,
  input  logic             i_rst_n,
  csr_sequencer_if.master  cif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_TRAP  = 3'd3,
    S_RET   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [11:0] MEPC_ADDR    = 12'h341;
  localparam logic [4:0]  CAUSE_ILLEG  = 5'd2;
  localparam logic [4:0]  CAUSE_BRK    = 5'd3;
  localparam logic [4:0]  CAUSE_ECALL  = 5'd11;
  localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0004;

  state_t      r_state;
  state_t      w_next;

  logic [2:0]  r_funct3;
  logic [11:0] r_csr_sel;
  logic [31:0] r_rs1_val;
  logic [4:0]  r_zimm;
  logic [4:0]  r_rs1_idx;
  logic [4:0]  r_rd_idx;
  logic [31:0] r_pc;
  logic        r_mret;
  logic        r_trapped;
  logic [4:0]  r_cause;
  logic [31:0] r_old_val;

  logic        w_accept;
  logic        w_load_cause;
  logic [4:0]  w_cause;
  logic        w_no_write;
  logic        w_ro_block;
  logic        w_priv;

  assign w_accept = (r_state == S_IDLE) && cif.start;
  assign w_priv   = (cif.funct3[1:0] == 2'b00);

  // RS/RC with a zero source never modify the CSR, so the write is skipped.
  assign w_no_write = (r_funct3[1:0] != 2'b01) &&
                      (r_funct3[2] ? (r_zimm == 5'd0) : (r_rs1_idx == 5'd0));

`ifdef CSR_RO_CHECK_EN
  assign w_ro_block = (r_csr_sel[11:10] == 2'b11);
`else
  assign w_ro_block = 1'b0;
`endif

  // state and operand registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_funct3  <= 3'd0;
      r_csr_sel <= 12'd0;
      r_rs1_val <= 32'd0;
      r_zimm    <= 5'd0;
      r_rs1_idx <= 5'd0;
      r_rd_idx  <= 5'd0;
      r_pc      <= 32'd0;
      r_mret    <= 1'b0;
      r_trapped <= 1'b0;
      r_cause   <= 5'd0;
      r_old_val <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_funct3  <= cif.funct3;
        r_csr_sel <= cif.csr_sel;
        r_rs1_val <= cif.rs1_val;
        r_zimm    <= cif.zimm;
        r_rs1_idx <= cif.rs1_idx;
        r_rd_idx  <= cif.rd_idx;
        r_pc      <= cif.pc;
        r_mret    <= w_priv && !cif.is_ecall && !cif.is_ebreak && cif.is_mret;
        r_trapped <= 1'b0;
        r_cause   <= 5'd0;
      end
      // later assignment wins, so a trap decided at acceptance sticks
      if (w_load_cause) begin
        r_cause   <= w_cause;
        r_trapped <= 1'b1;
      end
      if (r_state == S_READ) begin
        r_old_val <= cif.csr_out;
      end
    end
  end

  // next state and outputs
  always_comb begin
    w_next          = r_state;
    w_load_cause    = 1'b0;
    w_cause         = 5'd0;
    cif.csr_addr    = 12'd0;
    cif.bus         = 32'd0;
    cif.addr        = 32'd0;
    cif.read        = 1'b0;
    cif.write       = 1'b0;
    cif.trap        = 1'b0;
    cif.ret         = 1'b0;
    cif.write_type  = 2'd0;
    cif.trap_cause  = 5'd0;
    cif.busy        = (r_state != S_IDLE);
    cif.done        = 1'b0;
    cif.rd_we       = 1'b0;
    cif.rd_data     = 32'd0;
    cif.redirect    = 1'b0;
    cif.redirect_pc = 32'd0;

    case (r_state)
      S_IDLE: begin
        if (cif.start) begin
          if (w_priv) begin
            if (cif.is_ecall) begin
              w_next       = S_TRAP;
              w_load_cause = 1'b1;
              w_cause      = CAUSE_ECALL;
            end else if (cif.is_ebreak) begin
              w_next       = S_TRAP;
              w_load_cause = 1'b1;
              w_cause      = CAUSE_BRK;
            end else if (cif.is_mret) begin
              w_next = S_READ;
            end else begin
              w_next       = S_TRAP;
              w_load_cause = 1'b1;
              w_cause      = CAUSE_ILLEG;
            end
          end else begin
            w_next = S_READ;
          end
        end
      end

      S_READ: begin
        cif.read     = 1'b1;
        cif.csr_addr = r_mret ? MEPC_ADDR : r_csr_sel;
        if (cif.invalid) begin
          w_next       = S_TRAP;
          w_load_cause = 1'b1;
          w_cause      = CAUSE_ILLEG;
        end else if (r_mret) begin
          w_next = S_RET;
        end else if (w_no_write) begin
          w_next = S_DONE;
        end else if (w_ro_block) begin
          w_next       = S_TRAP;
          w_load_cause = 1'b1;
          w_cause      = CAUSE_ILLEG;
        end else begin
          w_next = S_WRITE;
        end
      end

      S_WRITE: begin
        cif.write      = 1'b1;
        cif.csr_addr   = r_csr_sel;
        cif.write_type = r_funct3[1:0];
        cif.bus        = r_funct3[2] ? {27'd0, r_zimm} : r_rs1_val;
        w_next         = S_DONE;
      end

      S_TRAP: begin
        cif.trap       = 1'b1;
        cif.bus        = r_pc;
        cif.addr       = r_pc;
        cif.trap_cause = r_cause;
        w_next         = S_DONE;
      end

      S_RET: begin
        cif.ret = 1'b1;
        w_next  = S_DONE;
      end

      S_DONE: begin
        cif.done = 1'b1;
        if (r_trapped) begin
          cif.redirect    = 1'b1;
          cif.redirect_pc = TRAP_VECTOR;
        end else if (r_mret) begin
          cif.redirect    = 1'b1;
          cif.redirect_pc = r_old_val;
        end else begin
          cif.rd_we   = (r_rd_idx != 5'd0);
          cif.rd_data = r_old_val;
        end
        w_next = S_IDLE;
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/csr_sequencer.md
CSR_SEQUENCER -- requirements
Module: csr_sequencer

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-003 start  in  1  one-cycle request; accepted only in IDLE.
REQ-004 funct3  in  3  SYSTEM funct3: [2] immediate form, [1:0] 01=RW, 10=RS, 11=RC, 00=priv op.
REQ-005 csr_sel  in  12  CSR address from instruction.
REQ-006 rs1_val / zimm / rs1_idx / rd_idx  in  32/5/5/5  operands; zimm zero-extended to 32.
REQ-007 is_ecall / is_ebreak / is_mret  in  1 each  priv op decode, valid with funct3=000.
REQ-008 pc  in  32  PC of the instruction.
REQ-009 csr_out / invalid  in  32/1  CSR file read data and illegal-address flag, combinational.
REQ-010 csr_addr / bus / addr  out  12/32/32  CSR file address, write or trap data, trap address.
REQ-011 read / write / trap / ret  out  1 each  CSR file strobes, each held for exactly one cycle.
REQ-012 write_type / trap_cause  out  2/5  write mode and trap cause.
REQ-013 busy / done  out  1/1  busy=state!=IDLE; done is a one-cycle completion pulse.
REQ-014 rd_we / rd_data  out  1/32  register write-back, valid only during done.
REQ-015 redirect / redirect_pc  out  1/32  PC redirect, valid only during done.

Function
REQ-016 States: IDLE, READ, WRITE, TRAP, RET, DONE; transitions occur on the clock edge only.
REQ-017 IDLE & start: priv op -> TRAP (ecall: cause 11; ebreak: cause 3) or READ (mret, csr_addr=12'h341); CSR op -> READ; funct3[1:0]=00 with no priv flag -> TRAP cause 2.
REQ-018 READ: read=1, csr_addr=csr_sel (or 12'h341), csr_out captured into old_val.
REQ-019 READ exit: invalid=1 -> TRAP cause 2, with no write issued.
REQ-020 READ exit, mret -> RET.
REQ-021 READ exit, RS or RC with zero write source (rs1_idx=0, or zimm=0 when funct3[2]=1) -> DONE.
REQ-022 READ exit, all other cases -> WRITE.
REQ-023 WRITE: write=1, write_type=funct3[1:0], bus = zimm zero-extended when funct3[2]=1, else rs1_val; next state DONE.
REQ-024 TRAP: trap=1, bus=pc, addr=pc, trap_cause held; next state DONE with redirect_pc=32'h4.
REQ-025 RET: ret=1; next state DONE with redirect_pc=old_val.
REQ-026 DONE: done=1; CSR op: rd_we=(rd_idx!=0), rd_data=old_val; trap/mret: rd_we=0, redirect=1; next state IDLE.
REQ-027 Latency from start to done: CSR op with write 3 cycles; CSR op without write 2 cycles; ecall/ebreak 2 cycles; mret 3 cycles; illegal CSR 3 cycles.
REQ-028 start while busy is ignored; no queuing.
REQ-029 Operands are registered at acceptance; input changes while busy have no effect.
REQ-030 At most one of read/write/trap/ret is high in any cycle.
REQ-031 When a strobe is low, its associated data outputs are 0.

Reset
REQ-032 rst=0 at any edge, including mid-operation: state=IDLE next cycle, no strobe issued afterwards.
REQ-033 Reset values: all outputs 0; old_val=0; latched operands=0.

Configuration
REQ-034 Macro: CSR_RO_CHECK_EN.
REQ-035 With CSR_RO_CHECK_EN defined: a CSR op that would enter WRITE while csr_sel[11:10]=2'b11 goes to TRAP cause 2 instead; no write is issued.
REQ-036 Without CSR_RO_CHECK_EN: such a write is issued normally.

Verification
REQ-037 Reset, start=1, funct3=001, csr_sel=340, rs1_val=DEADBEEF, rd=5, csr_out=0: read@T+1, write@T+2 (type 01, bus DEADBEEF), done@T+3 with rd_we=1, rd_data=0.
REQ-038 funct3=110, zimm=0, csr_sel=300, csr_out=88: write never asserted, done@T+2 with rd_data=88.
REQ-039 is_ecall, pc=100: trap@T+1 (cause 11, bus=100, addr=100), done@T+2 with redirect=1, redirect_pc=4.
REQ-040 is_mret, csr_out=200 on read: read@T+1 with csr_addr=341, ret@T+2, done@T+3 with redirect_pc=200.
REQ-041 csr_sel=7C0 with invalid=1: trap cause 2 @T+2, no write; with CSR_RO_CHECK_EN defined, funct3=001 and csr_sel=F11: trap cause 2, no write.
REQ-042 rst=0 asserted during WRITE: next cycle busy=0 and all strobes 0; start again during busy is ignored.
